uart_cmd_host: RTL and testbench



---
 rtl/uart_cmd_host.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_host.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_host.sv
// Host-side initiator for the UART "SR"/"SW" single-access command protocol.
// Define UART_CMD_HOST_TIMEOUT_EN to add an inter-character response timeout.
module uart_cmd_host #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [7:0]  tx_data,
    output logic        tx_push,
    input  logic        tx_full,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    input  logic        rx_empty
);

    typedef enum logic [1:0] {IDLE, TX_CMD, RX_RSP, DONE} state_t;

    state_t      state;
    logic        is_wr;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] acc_q;
    logic [7:0]  chk_q;
    logic [4:0]  idx;
    logic        bad_q;
    logic        mism_q;

`ifdef UART_CMD_HOST_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] byte_sum(input logic [31:0] a, input logic [31:0] d);
        return a[7:0] + a[15:8] + a[23:16] + a[31:24]
             + d[7:0] + d[15:8] + d[23:16] + d[31:24];
    endfunction

    function automatic logic [1:0] err_code(input logic bad, input logic mism);
        return bad ? 2'b01 : (mism ? 2'b10 : 2'b00);
    endfunction

    logic [2:0]  nsel;
    logic [31:0] tx_word;
    logic [7:0]  tx_char;
    logic        rx_hex;
    logic [3:0]  rx_nib;
    logic [3:0]  chk_nib;
    logic        bad_nx;
    logic        mism_nx;
    logic [31:0] acc_nx;
    logic        tx_last;
    logic        rx_last;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        tx_char = 8'h00;
        rx_hex  = 1'b0;
        rx_nib  = 4'h0;
        // Character index 2..9 selects an addr nibble, 10..17 a wdata nibble; both map to idx-2 mod 8.
        nsel    = idx[2:0] - 3'd2;
        tx_word = (idx < 5'd10) ? addr_q : wdata_q;
        case (idx)
            5'd0:    tx_char = 8'h53;
            5'd1:    tx_char = is_wr ? 8'h57 : 8'h52;
            default: tx_char = hex_enc(tx_word[{~nsel, 2'b00} +: 4]);
        endcase
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            rx_hex = 1'b1;
            rx_nib = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            rx_hex = 1'b1;
            rx_nib = rx_data[3:0] + 4'd9;
        end
        chk_nib = idx[0] ? chk_q[7:4] : chk_q[3:0];
        bad_nx  = bad_q | ~rx_hex;
        mism_nx = mism_q | (rx_nib != chk_nib);
        acc_nx  = acc_q;
        acc_nx[{~idx[2:0], 2'b00} +: 4] = rx_nib;
    end

    assign tx_last = (idx == (is_wr ? 5'd17 : 5'd9));
    assign rx_last = (idx == (is_wr ? 5'd1 : 5'd7));
    assign tx_push = reset_n && (state == TX_CMD) && !tx_full;
    assign tx_data = tx_push ? tx_char : 8'h00;
    assign rx_pop  = reset_n && (state == IDLE || state == RX_RSP) && !rx_empty;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            is_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            acc_q     <= '0;
            chk_q     <= '0;
            idx       <= '0;
            bad_q     <= 1'b0;
            mism_q    <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 2'b00;
`ifdef UART_CMD_HOST_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_wr     <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        chk_q     <= req_write ? byte_sum(req_addr, req_wdata) : 8'h00;
                        idx       <= '0;
                        acc_q     <= '0;
                        bad_q     <= 1'b0;
                        mism_q    <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= TX_CMD;
                    end
                end
                TX_CMD: begin
                    if (tx_push) begin
                        if (tx_last) begin
                            idx   <= '0;
                            state <= RX_RSP;
`ifdef UART_CMD_HOST_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                RX_RSP: begin
                    if (rx_pop) begin
                        acc_q  <= acc_nx;
                        bad_q  <= bad_nx;
                        mism_q <= is_wr & mism_nx;
`ifdef UART_CMD_HOST_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (rx_last) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= is_wr ? 32'h0 : acc_nx;
                            rsp_err   <= err_code(bad_nx, is_wr & mism_nx);
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
`ifdef UART_CMD_HOST_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= is_wr ? 32'h0 : acc_q;
                        rsp_err   <= 2'b11;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Self-checking bench for uart_cmd_host: vector table, FIFO models and a response scoreboard.
module tb_uart_cmd_host;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [7:0]  tx_data;
    logic        tx_push;
    logic        tx_full;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        rx_empty;

    always #5 clk = ~clk;

    uart_cmd_host #(.TIMEOUT_CYCLES(100), .TO_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .tx_data   (tx_data),
        .tx_push   (tx_push),
        .tx_full   (tx_full),
        .rx_data   (rx_data),
        .rx_pop    (rx_pop),
        .rx_empty  (rx_empty)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        string       rsp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
        int          exp_lat;
        int          stall_at;
        int          stall_len;
        int          n_stale;
        bit          early;
    } vec_t;

    logic [7:0] rx_q[$];
    logic [7:0] tx_got[$];
    exp_t       sb[$];
    vec_t       vecs[8];

    int n_total = 0;
    int n_bad   = 0;
    int cyc = 0;
    int n_rsp = 0;
    int n_sent = 0;
    int accept_cyc = -1;
    int rsp_cyc = -1;
    int stall_at = 0;
    int stall_len = 0;
    int stall_left = 0;
    bit stall_armed = 1'b0;
    bit txdata_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=\"%s\" expected=\"%s\"", name, got, exp);
        end
    endtask

    function automatic string hex8(input logic [31:0] v);
        string digits = "0123456789ABCDEF";
        string s = "";
        for (int i = 7; i >= 0; i--) begin
            logic [3:0] n = v[i*4 +: 4];
            s = $sformatf("%s%c", s, digits[n]);
        end
        return s;
    endfunction

    function automatic string exp_tx(input bit w, input logic [31:0] a, input logic [31:0] d);
        return w ? {"SW", hex8(a), hex8(d)} : {"SR", hex8(a)};
    endfunction

    function automatic string tx_str();
        string s = "";
        foreach (tx_got[i]) s = $sformatf("%s%c", s, tx_got[i]);
        return s;
    endfunction

    task automatic rx_refresh();
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    endtask

    task automatic rx_push_str(input string s);
        for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
        rx_refresh();
    endtask

    // One clock: sample at the falling edge, then apply FIFO effects and new inputs 1ns after the rising edge.
    task automatic tick();
        bit do_pop;
        logic [7:0] junk;
        exp_t e;
        @(negedge clk);
        cyc++;
        if (tx_push) tx_got.push_back(tx_data);
        else if (tx_data !== 8'h00) txdata_bad = 1'b1;
        do_pop = rx_pop;
        if (req_valid && req_ready) accept_cyc = cyc;
        if (rsp_valid) begin
            n_rsp++;
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(n_rsp), 32'(n_sent));
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        if (stall_armed && tx_got.size() == stall_at) begin
            stall_left  = stall_len;
            stall_armed = 1'b0;
        end
        @(posedge clk);
        #1;
        if (do_pop && rx_q.size() > 0) junk = rx_q.pop_front();
        if (stall_left > 0) begin
            tx_full = 1'b1;
            stall_left--;
        end else begin
            tx_full = 1'b0;
        end
        rx_refresh();
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int txlen = v.w ? 18 : 10;
        int n0;
        bit rsp_pushed;
        exp_t e;
        for (int k = 0; k < 50 && !req_ready; k++) tick();
        for (int i = 0; i < v.n_stale; i++) rx_q.push_back(8'h5A);
        rx_refresh();
        for (int i = 1; i < v.n_stale; i++) tick();
        tx_got.delete();
        txdata_bad  = 1'b0;
        stall_at    = v.stall_at;
        stall_len   = v.stall_len;
        stall_armed = (v.stall_len > 0);
        req_write   = v.w;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        req_valid   = 1'b1;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        n_sent++;
        n0 = n_rsp;
        tick();
        req_valid = 1'b0;
        check({tag, "_accept"}, 32'(accept_cyc), 32'(cyc));
        rsp_pushed = 1'b0;
        if (v.early) begin
            rx_push_str(v.rsp);
            rsp_pushed = 1'b1;
        end
        for (int k = 0; k < 600 && n_rsp == n0; k++) begin
            tick();
            if (!rsp_pushed && tx_got.size() == txlen) begin
                rx_push_str(v.rsp);
                rsp_pushed = 1'b1;
            end
        end
        if (n_rsp == n0) begin
            check({tag, "_rsp_wait_expired"}, 32'(n_rsp), 32'(n0 + 1));
            return;
        end
        check_str({tag, "_tx_chars"}, tx_str(), exp_tx(v.w, v.addr, v.wdata));
        check({tag, "_tx_data_idle_zero"}, 32'(txdata_bad), 32'h0);
        if (v.exp_lat >= 0) check({tag, "_latency"}, 32'(rsp_cyc - accept_cyc), 32'(v.exp_lat));
        check({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'h0);
        check({tag, "_ready_after"}, 32'(req_ready), 32'h1);
        tick();
        tick();
        check({tag, "_rdata_held"}, rsp_rdata, v.exp_rdata);
        check({tag, "_rx_fifo_empty"}, 32'(rx_q.size()), 32'h0);
    endtask

    initial begin
        int n0;
        vec_t tv;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        tx_full   = 1'b0;
        rx_refresh();

        //          w  addr          wdata         rsp         rdata         err    lat st  sl stale early
        vecs[0] = '{1'b0, 32'h40000004, 32'h0,        "DEADBEEF", 32'hDEADBEEF, 2'b00, 19, 0, 0, 0, 1'b0};
        vecs[1] = '{1'b1, 32'h00001000, 32'h12345678, "42",       32'h0,        2'b00, 21, 0, 0, 0, 1'b0};
        vecs[2] = '{1'b1, 32'h00001000, 32'h12345678, "24",       32'h0,        2'b10, 21, 0, 0, 0, 1'b0};
        vecs[3] = '{1'b0, 32'h89ABCDEF, 32'h0,        "12G45678", 32'h12045678, 2'b01, 19, 0, 0, 0, 1'b0};
        vecs[4] = '{1'b0, 32'hA5A5F00F, 32'h0,        "0badCAFE", 32'h0BADCAFE, 2'b00, 24, 4, 5, 3, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, "8f",       32'h0,        2'b00, 21, 0, 0, 1, 1'b1};
        vecs[6] = '{1'b1, 32'h00001000, 32'h12345678, "4Z",       32'h0,        2'b01, 21, 0, 0, 0, 1'b0};
        vecs[7] = '{1'b0, 32'h00000000, 32'h0,        "ffffffff", 32'hFFFFFFFF, 2'b00, 19, 0, 0, 0, 1'b0};

        tick();
        tick();
        check("reset_req_ready", 32'(req_ready), 32'h1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        check("reset_tx_push", 32'(tx_push), 32'h0);
        check("reset_tx_data", 32'(tx_data), 32'h0);
        check("reset_rx_pop", 32'(rx_pop), 32'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a command: no response may follow, and the block drains as idle.
        n0 = n_rsp;
        req_write = 1'b0;
        req_addr  = 32'h12345678;
        req_valid = 1'b1;
        tx_got.delete();
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 50 && tx_got.size() < 5; k++) tick();
        reset_n = 1'b0;
        tick();
        check("midreset_req_ready", 32'(req_ready), 32'h1);
        check("midreset_tx_push", 32'(tx_push), 32'h0);
        check("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
        reset_n = 1'b1;
        rx_push_str("A");
        for (int k = 0; k < 20; k++) tick();
        check("midreset_no_rsp", 32'(n_rsp), 32'(n0));
        check("midreset_drained", 32'(rx_q.size()), 32'h0);

`ifdef UART_CMD_HOST_TIMEOUT_EN
        tv = '{1'b0, 32'h40000004, 32'h0, "DEAD", 32'hDEAD0000, 2'b11, 115, 0, 0, 0, 1'b0};
        run_txn(tv, "timeout");
`else
        tv = vecs[0];
        run_txn(tv, "repeat_read");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
